// File: rtl/enemy_ctrl.sv
// Autonomous Bomberman enemy: random-walk sprite, explosion kill, player-contact flag.
// Optional respawn after death is enabled by defining ENEMY_RESPAWN_EN.
module enemy_ctrl #(
    parameter int unsigned TILE           = 16,
    parameter logic [9:0]  START_X        = 10'd304,
    parameter logic [9:0]  START_Y        = 10'd224,
    parameter int unsigned STEP_DIV       = 1_000_000,
    parameter int unsigned EXPL_REACH     = 2,
    parameter int unsigned DYING_CYCLES   = 50_000_000,
    parameter logic [11:0] ENEMY_RGB      = 12'hF0F,
    parameter int unsigned RESPAWN_CYCLES = 200_000_000
) (
    input  logic        sys_clk,
    input  logic        Reset,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [9:0]  e_x,
    input  logic [9:0]  e_y,
    input  logic        explosion_SCEN,
    input  logic [3:0]  enemy_blocked,
    output logic [9:0]  enemy_x,
    output logic [9:0]  enemy_y,
    output logic        enemy_on,
    output logic [11:0] rgb_out,
    output logic        hit_bomberman
);

    typedef enum logic [1:0] {StAlive, StDying, StDead} state_e;
    typedef enum logic [1:0] {DirLeft, DirRight, DirUp, DirDown} dir_e;

    localparam int unsigned TB    = $clog2(TILE);
    localparam logic [10:0] TILE11 = 11'(TILE);
    localparam logic [10:0] ARM11  = 11'((EXPL_REACH + 1) * TILE);
    localparam logic [9:0]  X_MAX  = 10'(640 - TILE);
    localparam logic [9:0]  Y_MAX  = 10'(480 - TILE);
    localparam logic [26:0] STEP_LAST = 27'(STEP_DIV - 1);

    // One counter serves both the death flash and the respawn wait; bit 22 drives the flash.
    localparam int unsigned CW_D  = $clog2(DYING_CYCLES);
    localparam int unsigned CW_R  = $clog2(RESPAWN_CYCLES);
    localparam int unsigned CW_A  = (CW_D > CW_R) ? CW_D : CW_R;
    localparam int unsigned CNT_W = (CW_A > 23) ? CW_A : 23;
    localparam logic [CNT_W-1:0] DYING_LAST = CNT_W'(DYING_CYCLES - 1);

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    state_e           state_q;
    dir_e             dir_q;
    logic [26:0]      step_cnt_q;
    logic [7:0]       lfsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic       tick;
    logic       lfsr_fb;
    logic       blocked_eff;
    logic       junction;
    logic       kill;
    logic       overlap_player;
    dir_e       rand_dir;
    dir_e       turn_dir;
    logic [10:0] ex_d, ey_d, bx_d, by_d;
    logic [9:0] ox, oy;
    logic       eye;

    assign tick     = (step_cnt_q == STEP_LAST);
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign rand_dir = dir_e'(lfsr_q[1:0]);
    assign turn_dir = (rand_dir == dir_q) ? dir_e'(dir_q + 2'd1) : rand_dir;
    assign junction = (enemy_x[TB-1:0] == '0) && (enemy_y[TB-1:0] == '0)
                      && (lfsr_q[7:5] == 3'd0);

    assign ex_d = abs_diff(enemy_x, e_x);
    assign ey_d = abs_diff(enemy_y, e_y);
    assign bx_d = abs_diff(enemy_x, b_x);
    assign by_d = abs_diff(enemy_y, b_y);

    assign kill = explosion_SCEN && (((ex_d < TILE11) && (ey_d < ARM11)) ||
                                     ((ey_d < TILE11) && (ex_d < ARM11)));
    assign overlap_player = (bx_d < TILE11) && (by_d < TILE11);

`ifdef ENEMY_RESPAWN_EN
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESPAWN_CYCLES - 1);
    logic player_at_start;
    assign player_at_start = (abs_diff(START_X, b_x) < TILE11) &&
                             (abs_diff(START_Y, b_y) < TILE11);
`endif

    // Playfield edges count as walls.
    always_comb begin
        blocked_eff = 1'b0;
        unique case (dir_q)
            DirLeft:  blocked_eff = enemy_blocked[3] || (enemy_x == 10'd0);
            DirRight: blocked_eff = enemy_blocked[2] || (enemy_x >= X_MAX);
            DirUp:    blocked_eff = enemy_blocked[1] || (enemy_y == 10'd0);
            DirDown:  blocked_eff = enemy_blocked[0] || (enemy_y >= Y_MAX);
        endcase
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= StAlive;
            dir_q         <= DirLeft;
            step_cnt_q    <= '0;
            lfsr_q        <= 8'hA5;
            cnt_q         <= '0;
            enemy_x       <= START_X;
            enemy_y       <= START_Y;
            hit_bomberman <= 1'b0;
        end else begin
            step_cnt_q    <= tick ? 27'd0 : step_cnt_q + 27'd1;
            if (tick) lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            hit_bomberman <= (state_q == StAlive) && overlap_player;

            case (state_q)
                StAlive: begin
                    if (kill) begin
                        state_q <= StDying;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        if (blocked_eff) begin
                            dir_q <= turn_dir;
                        end else begin
                            unique case (dir_q)
                                DirLeft:  enemy_x <= enemy_x - 10'd1;
                                DirRight: enemy_x <= enemy_x + 10'd1;
                                DirUp:    enemy_y <= enemy_y - 10'd1;
                                DirDown:  enemy_y <= enemy_y + 10'd1;
                            endcase
                            if (junction) dir_q <= rand_dir;
                        end
                    end
                end
                StDying: begin
                    if (cnt_q == DYING_LAST) begin
                        state_q <= StDead;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDead: begin
`ifdef ENEMY_RESPAWN_EN
                    // Wait saturates, so respawn follows as soon as the start tile is clear.
                    if (cnt_q != RESP_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!player_at_start) begin
                        state_q <= StAlive;
                        dir_q   <= DirLeft;
                        enemy_x <= START_X;
                        enemy_y <= START_Y;
                        cnt_q   <= '0;
                    end
`else
                    state_q <= StDead;
`endif
                end
                default: state_q <= StAlive;
            endcase
        end
    end

    assign ox  = v_x - enemy_x;
    assign oy  = v_y - enemy_y;
    assign eye = (ox >= 10'd4) && (ox <= 10'd11) && (oy >= 10'd4) && (oy <= 10'd7);

    always_comb begin
        enemy_on = (state_q != StDead) &&
                   ({1'b0, v_x} >= {1'b0, enemy_x}) && ({1'b0, v_x} < {1'b0, enemy_x} + TILE11) &&
                   ({1'b0, v_y} >= {1'b0, enemy_y}) && ({1'b0, v_y} < {1'b0, enemy_y} + TILE11);
    end

    always_comb begin
        rgb_out = 12'h000;
        case (state_q)
            StAlive: rgb_out = eye ? 12'h000 : ENEMY_RGB;
            StDying: rgb_out = cnt_q[22] ? ENEMY_RGB : 12'hFFF;
            default: rgb_out = 12'h000;
        endcase
    end

endmodule

// File: tb/tb_enemy_ctrl.sv
// Directed self-checking bench for enemy_ctrl with a fast step divider and short death phase.
module tb_enemy_ctrl;
    logic        sys_clk;
    logic        Reset;
    logic [9:0]  v_x, v_y, b_x, b_y, e_x, e_y;
    logic        explosion_SCEN;
    logic [3:0]  enemy_blocked;
    logic [9:0]  enemy_x, enemy_y;
    logic        enemy_on;
    logic [11:0] rgb_out;
    logic        hit_bomberman;

    int n_checks = 0;
    int n_fail   = 0;

    enemy_ctrl #(
        .STEP_DIV(4),
        .DYING_CYCLES(20),
        .RESPAWN_CYCLES(10)
    ) dut (
        .sys_clk(sys_clk),
        .Reset(Reset),
        .v_x(v_x),
        .v_y(v_y),
        .b_x(b_x),
        .b_y(b_y),
        .e_x(e_x),
        .e_y(e_y),
        .explosion_SCEN(explosion_SCEN),
        .enemy_blocked(enemy_blocked),
        .enemy_x(enemy_x),
        .enemy_y(enemy_y),
        .enemy_on(enemy_on),
        .rgb_out(rgb_out),
        .hit_bomberman(hit_bomberman)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clk(1);
        Reset = 1'b0;
    endtask

    task automatic pulse_expl(input logic [9:0] x, input logic [9:0] y);
        e_x = x;
        e_y = y;
        explosion_SCEN = 1'b1;
        clk(1);
        explosion_SCEN = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        v_x = 10'd304; v_y = 10'd224;
        #2;
        n_checks++;
        if (enemy_x !== 10'd304) begin n_fail++; $display("FAIL reset_x got %0d want 304", enemy_x); end
        n_checks++;
        if (enemy_y !== 10'd224) begin n_fail++; $display("FAIL reset_y got %0d want 224", enemy_y); end
        n_checks++;
        if (hit_bomberman !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", hit_bomberman); end
        n_checks++;
        if (enemy_on !== 1'b1) begin n_fail++; $display("FAIL reset_on got %b want 1", enemy_on); end
        n_checks++;
        if (rgb_out !== 12'hF0F) begin n_fail++; $display("FAIL reset_body got %h want F0F", rgb_out); end
        v_x = 10'd312; v_y = 10'd228;
        #1;
        n_checks++;
        if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_eye got %h want 000", rgb_out); end
        v_x = 10'd320; v_y = 10'd224;
        #1;
        n_checks++;
        if (enemy_on !== 1'b0) begin n_fail++; $display("FAIL reset_on_edge got %b want 0", enemy_on); end
        clk(1);
        Reset = 1'b0;
    endtask

    task automatic test_walk();
        clk(48);
        n_checks++;
        if (enemy_x !== 10'd292) begin n_fail++; $display("FAIL walk_x got %0d want 292", enemy_x); end
        n_checks++;
        if (enemy_y !== 10'd224) begin n_fail++; $display("FAIL walk_y got %0d want 224", enemy_y); end
        v_x = 10'd292; v_y = 10'd224;
        #1;
        n_checks++;
        if (enemy_on !== 1'b1) begin n_fail++; $display("FAIL walk_on_corner got %b want 1", enemy_on); end
        v_x = 10'd307; v_y = 10'd239;
        #1;
        n_checks++;
        if (enemy_on !== 1'b1) begin n_fail++; $display("FAIL walk_on_far got %b want 1", enemy_on); end
        v_x = 10'd308; v_y = 10'd224;
        #1;
        n_checks++;
        if (enemy_on !== 1'b0) begin n_fail++; $display("FAIL walk_on_out got %b want 0", enemy_on); end
    endtask

    task automatic test_blocked();
        logic [7:0] l;
        logic [1:0] nd;
        logic [9:0] ex, ey;
        l = 8'hA5;
        for (int i = 0; i < 12; i++) l = lfsr_next(l);
        nd = (l[1:0] == 2'd0) ? 2'd1 : l[1:0];
        ex = 10'd292; ey = 10'd224;
        case (nd)
            2'd1: ex = 10'd293;
            2'd2: ey = 10'd223;
            default: ey = 10'd225;
        endcase
        enemy_blocked = 4'b1000;
        clk(4);
        n_checks++;
        if (enemy_x !== 10'd292 || enemy_y !== 10'd224) begin
            n_fail++; $display("FAIL blocked_hold got (%0d,%0d) want (292,224)", enemy_x, enemy_y);
        end
        enemy_blocked = 4'b0000;
        clk(4);
        n_checks++;
        if (enemy_x !== ex || enemy_y !== ey) begin
            n_fail++;
            $display("FAIL blocked_turn got (%0d,%0d) want (%0d,%0d)", enemy_x, enemy_y, ex, ey);
        end
    endtask

    task automatic test_explosion();
        v_x = 10'd304; v_y = 10'd224;
        do_reset();
        pulse_expl(10'd352, 10'd224);
        n_checks++;
        if (rgb_out !== 12'hF0F) begin n_fail++; $display("FAIL expl_far_x got %h want F0F", rgb_out); end
        do_reset();
        pulse_expl(10'd320, 10'd240);
        n_checks++;
        if (rgb_out !== 12'hF0F) begin n_fail++; $display("FAIL expl_diag got %h want F0F", rgb_out); end
        do_reset();
        pulse_expl(10'd336, 10'd224);
        n_checks++;
        if (rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL expl_kill_rgb got %h want FFF", rgb_out); end
        clk(19);
        n_checks++;
        if (enemy_on !== 1'b1) begin n_fail++; $display("FAIL dying_on got %b want 1", enemy_on); end
        clk(1);
        n_checks++;
        if (enemy_on !== 1'b0) begin n_fail++; $display("FAIL dead_on got %b want 0", enemy_on); end
        n_checks++;
        if (enemy_x !== 10'd304) begin n_fail++; $display("FAIL dead_frozen got %0d want 304", enemy_x); end
        do_reset();
        #1;
        n_checks++;
        if (enemy_on !== 1'b1 || rgb_out !== 12'hF0F) begin
            n_fail++; $display("FAIL reset_from_dead got on=%b rgb=%h want on=1 rgb=F0F", enemy_on, rgb_out);
        end
        do_reset();
        pulse_expl(10'd304, 10'd256);
        n_checks++;
        if (rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL expl_kill_y got %h want FFF", rgb_out); end
    endtask

    task automatic test_kill_on_tick();
        do_reset();
        clk(3);
        pulse_expl(10'd336, 10'd224);
        n_checks++;
        if (enemy_x !== 10'd304) begin n_fail++; $display("FAIL kill_tick_x got %0d want 304", enemy_x); end
        n_checks++;
        if (rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL kill_tick_rgb got %h want FFF", rgb_out); end
    endtask

    task automatic test_player();
        do_reset();
        b_x = 10'd310; b_y = 10'd230;
        clk(1);
        n_checks++;
        if (hit_bomberman !== 1'b1) begin n_fail++; $display("FAIL hit_overlap got %b want 1", hit_bomberman); end
        b_x = 10'd320; b_y = 10'd224;
        clk(1);
        n_checks++;
        if (hit_bomberman !== 1'b0) begin n_fail++; $display("FAIL hit_adjacent got %b want 0", hit_bomberman); end
        do_reset();
        b_x = 10'd304; b_y = 10'd224;
        pulse_expl(10'd304, 10'd224);
        n_checks++;
        if (hit_bomberman !== 1'b1) begin n_fail++; $display("FAIL hit_kill_edge got %b want 1", hit_bomberman); end
        clk(1);
        n_checks++;
        if (hit_bomberman !== 1'b0) begin n_fail++; $display("FAIL hit_dying got %b want 0", hit_bomberman); end
        b_x = 10'd0; b_y = 10'd0;
    endtask

`ifdef ENEMY_RESPAWN_EN
    task automatic test_respawn();
        v_x = 10'd304; v_y = 10'd224;
        do_reset();
        pulse_expl(10'd304, 10'd224);
        clk(20);
        clk(9);
        n_checks++;
        if (enemy_on !== 1'b0) begin n_fail++; $display("FAIL respawn_wait got %b want 0", enemy_on); end
        clk(1);
        n_checks++;
        if (enemy_on !== 1'b1 || enemy_x !== 10'd304) begin
            n_fail++; $display("FAIL respawn got on=%b x=%0d want on=1 x=304", enemy_on, enemy_x);
        end
        b_x = 10'd304; b_y = 10'd224;
        pulse_expl(10'd304, 10'd224);
        clk(35);
        n_checks++;
        if (enemy_on !== 1'b0) begin n_fail++; $display("FAIL respawn_deferred got %b want 0", enemy_on); end
        b_x = 10'd0; b_y = 10'd0;
        clk(1);
        n_checks++;
        if (enemy_on !== 1'b1) begin n_fail++; $display("FAIL respawn_clear got %b want 1", enemy_on); end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        v_x = '0; v_y = '0; b_x = '0; b_y = '0; e_x = '0; e_y = '0;
        explosion_SCEN = 1'b0;
        enemy_blocked = 4'b0000;
        test_reset();
        test_walk();
        test_blocked();
        test_explosion();
        test_kill_on_tick();
        test_player();
`ifdef ENEMY_RESPAWN_EN
        test_respawn();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
